// File: rtl/dog_pkg.sv
// Shared definitions for the DoG window generator.
//   DOG_DW  : default DoG sample width
//   state_t : frame-tracking FSM state
//   win_idx : bit offset of window element (r,c) in the flattened window bus
package dog_pkg;

  localparam int DOG_DW = 17;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Element (r,c) of a k x k window of dw-bit samples; r=0 oldest row, c=0 oldest column.
  function automatic int win_idx(input int r, input int c, input int k, input int dw = DOG_DW);
    return (r * k + c) * dw;
  endfunction

endpackage

// File: rtl/dog_line_buffer.sv
// Circular delay line of DEPTH samples: on each enabled cycle the oldest
// sample is presented on dout and overwritten with din, so dout is the
// sample written exactly DEPTH enables earlier.
//   clk  : clock
//   rst  : synchronous active-high reset (pointer only; storage is not cleared)
//   en   : advance the delay line
//   din  : sample written this enable
//   dout : sample written DEPTH enables ago
module dog_line_buffer #(
  parameter int DW    = 17,
  parameter int DEPTH = 640
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [DW-1:0] din,
  output logic signed [DW-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic signed [DW-1:0] mem [DEPTH];
  logic [AW-1:0]        ptr;

  // Read-before-write at the same address gives a delay of exactly DEPTH.
  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    end
  end

endmodule

// File: rtl/dog_window_gen.sv
// Streaming K x K neighbourhood generator for one DoG plane. Samples arrive
// in raster order; K-1 line buffers plus a K x K shift window produce the full
// neighbourhood of every interior pixel one cycle after its bottom-right pixel.
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : in_data / in_sof qualified
//   in_sof    : first pixel of a frame
//   in_data   : signed DoG sample
//   out_valid : single-cycle window strobe
//   out_win   : window, element (r,c) at [(r*K+c)*DW +: DW]
//   out_x/y   : window centre coordinates
//   out_eof   : last window of the frame
//   err_sof   : sticky, SOF seen mid-frame
module dog_window_gen
  import dog_pkg::*;
#(
  parameter int DW    = DOG_DW,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int K     = 3,
  parameter int XW    = $clog2(IMG_W),
  parameter int YW    = $clog2(IMG_H)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  output logic [K*K*DW-1:0]    out_win,
  output logic [XW-1:0]        out_x,
  output logic [YW-1:0]        out_y,
  output logic                 out_eof,
  output logic                 err_sof
);

  state_t        state;
  logic [XW-1:0] col;
  logic [YW-1:0] row;

  logic          restart, acc, last, emit;
  logic [XW-1:0] cur_col;
  logic [YW-1:0] cur_row;

  logic signed [DW-1:0] lb_out  [K-1];
  logic signed [DW-1:0] win_p0  [K][K];
  logic signed [DW-1:0] win_nxt [K][K];

  // An SOF sample is always pixel (0,0), whatever the counters say.
  always_comb begin
    restart = in_valid && in_sof;
    acc     = in_valid && (in_sof || (state == RUN));
    cur_col = restart ? '0 : col;
    cur_row = restart ? '0 : row;
    last    = (cur_col == XW'(IMG_W - 1)) && (cur_row == YW'(IMG_H - 1));
    emit    = acc && (cur_col >= XW'(K - 1)) && (cur_row >= YW'(K - 1));
  end

  // Cascade: lb_out[0] is one line above the incoming sample, lb_out[K-2] is K-1 lines above.
  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    if (i == 0) begin : g_first
      dog_line_buffer #(.DW(DW), .DEPTH(IMG_W)) u_lb (
        .clk (clk), .rst (rst), .en (acc), .din (in_data), .dout (lb_out[i])
      );
    end else begin : g_next
      dog_line_buffer #(.DW(DW), .DEPTH(IMG_W)) u_lb (
        .clk (clk), .rst (rst), .en (acc), .din (lb_out[i-1]), .dout (lb_out[i])
      );
    end
  end

  // Shift the window one column left; the new right-hand column is the
  // vertical slice ending at the incoming sample.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_nxt[r][c] = win_p0[r][c+1];
      end
    end
    for (int r = 0; r < K - 1; r++) begin
      win_nxt[r][K-1] = lb_out[K-2-r];
    end
    win_nxt[K-1][K-1] = in_data;
  end

  // Stage p0: window shift register (data only, no reset)
  always_ff @(posedge clk) begin
    if (acc) begin
      win_p0 <= win_nxt;
    end
  end

  // Stage p0: FSM, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      err_sof   <= 1'b0;
      out_valid <= 1'b0;
      out_win   <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_eof   <= 1'b0;
    end else begin
      out_valid <= emit;
      if (restart && (state == RUN)) begin
        err_sof <= 1'b1;
      end
      if (acc) begin
        if (last) begin
          state <= IDLE;
          col   <= '0;
          row   <= '0;
        end else begin
          state <= RUN;
          if (cur_col == XW'(IMG_W - 1)) begin
            col <= '0;
            row <= cur_row + YW'(1);
          end else begin
            col <= cur_col + XW'(1);
            row <= cur_row;
          end
        end
      end
      if (emit) begin
        out_x   <= cur_col - XW'((K - 1) / 2);
        out_y   <= cur_row - YW'((K - 1) / 2);
        out_eof <= last;
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K; c++) begin
            out_win[win_idx(r, c, K, DW) +: DW] <= win_nxt[r][c];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dog_window_gen.sv
// Self-checking bench for dog_window_gen (DW=17, 8x6 image, K=3).
// A reference model records every accepted pixel into an image array and
// pushes the expected window to a scoreboard queue; a negedge monitor pops
// and compares each window, including its exact emission cycle.
module tb_dog_window_gen;

  localparam int DW = 17;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int K  = 3;
  localparam int XW = 3;
  localparam int YW = 3;
  localparam int WW = K * K * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [WW-1:0] out_win;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          out_eof;
  logic          err_sof;

  dog_window_gen #(
    .DW(DW), .IMG_W(IW), .IMG_H(IH), .K(K), .XW(XW), .YW(YW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .out_valid(out_valid), .out_win(out_win), .out_x(out_x), .out_y(out_y),
    .out_eof(out_eof), .err_sof(err_sof)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            x;
    int            y;
    bit            eof;
    logic [WW-1:0] win;
    int            cyc;
  } win_t;

  typedef struct {
    int idx;
    int x;
    int y;
    int ctr;
    int e00;
    int e22;
    bit eof;
  } vec_t;

  win_t exp_q[$];
  win_t obs_q[$];
  win_t ref_q[$];
  vec_t tbl[4];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int el(input logic [WW-1:0] w, input int r, input int c);
    logic [DW-1:0] v;
    v = w[(r * K + c) * DW +: DW];
    return int'(v);
  endfunction

  // Reference model state
  logic [DW-1:0] img [IH][IW];
  bit m_run = 1'b0;
  bit m_err = 1'b0;
  int m_col = 0;
  int m_row = 0;

  task automatic model(input bit v, input bit s, input logic [DW-1:0] d, input bit r);
    int   c, rw;
    win_t w;
    if (r) begin
      m_run = 0; m_err = 0; m_col = 0; m_row = 0;
      return;
    end
    if (!v) return;
    if (!m_run && !s) return;
    if (s) begin
      if (m_run) m_err = 1;
      c = 0; rw = 0;
    end else begin
      c = m_col; rw = m_row;
    end
    img[rw][c] = d;
    if (c >= K - 1 && rw >= K - 1) begin
      w.x   = c - (K - 1) / 2;
      w.y   = rw - (K - 1) / 2;
      w.eof = (c == IW - 1) && (rw == IH - 1);
      w.cyc = cyc;
      w.win = '0;
      for (int rr = 0; rr < K; rr++)
        for (int cc = 0; cc < K; cc++)
          w.win[(rr * K + cc) * DW +: DW] = img[rw - K + 1 + rr][c - K + 1 + cc];
      exp_q.push_back(w);
    end
    if (c == IW - 1 && rw == IH - 1) begin
      m_run = 0; m_col = 0; m_row = 0;
    end else begin
      m_run = 1;
      if (c == IW - 1) begin
        m_col = 0; m_row = rw + 1;
      end else begin
        m_col = c + 1; m_row = rw;
      end
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then update the model.
  task automatic step(input bit v, input bit s, input logic [DW-1:0] d, input bit r);
    in_valid = v; in_sof = s; in_data = d; rst = r;
    @(posedge clk);
    #1;
    model(v, s, d, r);
    in_valid = 1'b0; in_sof = 1'b0; rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] pix(input int n);
    return DW'((n / IW) * 16 + (n % IW));
  endfunction

  task automatic frame(input bit neg, input bit gaps);
    for (int n = 0; n < IW * IH; n++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom_range(0, 1)), DW'($urandom), 1'b0);
      end
      step(1'b1, n == 0, neg ? {DW{1'b1}} : pix(n), 1'b0);
    end
    repeat (3) step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic check_table(input string tag);
    win_t w;
    for (int i = 0; i < 4; i++) begin
      if (tbl[i].idx < obs_q.size()) begin
        w = obs_q[tbl[i].idx];
        chk({tag, "_x"},   w.x,           tbl[i].x);
        chk({tag, "_y"},   w.y,           tbl[i].y);
        chk({tag, "_eof"}, w.eof,         tbl[i].eof);
        chk({tag, "_ctr"}, el(w.win,1,1), tbl[i].ctr);
        chk({tag, "_e00"}, el(w.win,0,0), tbl[i].e00);
        chk({tag, "_e22"}, el(w.win,2,2), tbl[i].e22);
      end else begin
        chk({tag, "_present"}, obs_q.size(), tbl[i].idx + 1);
      end
    end
  endtask

  task automatic same_as_ref(input string tag);
    chk({tag, "_count"}, obs_q.size(), ref_q.size());
    for (int i = 0; i < ref_q.size() && i < obs_q.size(); i++) begin
      chk({tag, "_x"},   obs_q[i].x,   ref_q[i].x);
      chk({tag, "_y"},   obs_q[i].y,   ref_q[i].y);
      chk({tag, "_eof"}, obs_q[i].eof, ref_q[i].eof);
      chk({tag, "_win"}, obs_q[i].win, ref_q[i].win);
    end
  endtask

  // Monitor: compare every window against the scoreboard away from the active edge.
  win_t mon_e, mon_o;
  always @(negedge clk) begin
    chk("err_sof", err_sof, m_err);
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window actual x=%0d y=%0d required none", out_x, out_y);
      end else begin
        mon_e = exp_q.pop_front();
        chk("win_x",   out_x,   mon_e.x);
        chk("win_y",   out_y,   mon_e.y);
        chk("win_eof", out_eof, mon_e.eof);
        chk("win_data", out_win, mon_e.win);
        chk("win_cycle", cyc,   mon_e.cyc);
      end
      mon_o.x = out_x; mon_o.y = out_y; mon_o.eof = out_eof; mon_o.win = out_win; mon_o.cyc = cyc;
      obs_q.push_back(mon_o);
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_window actual none required x=%0d y=%0d cycle=%0d", mon_e.x, mon_e.y, mon_e.cyc);
    end
  end

  initial begin
    tbl[0] = '{idx: 0,  x: 1, y: 1, ctr: 17, e00: 0,  e22: 34, eof: 1'b0};
    tbl[1] = '{idx: 5,  x: 6, y: 1, ctr: 22, e00: 5,  e22: 39, eof: 1'b0};
    tbl[2] = '{idx: 6,  x: 1, y: 2, ctr: 33, e00: 16, e22: 50, eof: 1'b0};
    tbl[3] = '{idx: 23, x: 6, y: 4, ctr: 70, e00: 53, e22: 87, eof: 1'b1};

    // Reset state
    step(1'b0, 1'b0, '0, 1'b1);
    chk("rst_valid", out_valid, 0);
    chk("rst_win",   out_win,   0);
    chk("rst_x",     out_x,     0);
    chk("rst_y",     out_y,     0);
    chk("rst_eof",   out_eof,   0);
    chk("rst_err",   err_sof,   0);

    // Continuous frame
    obs_q.delete();
    frame(1'b0, 1'b0);
    chk("s1_count", obs_q.size(), 24);
    check_table("s1");
    ref_q = obs_q;

    // Same frame with random idle cycles
    obs_q.delete();
    frame(1'b0, 1'b1);
    same_as_ref("s2");

    // Samples with no SOF are ignored in IDLE
    obs_q.delete();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, pix(i + 9), 1'b0);
    repeat (2) step(1'b0, 1'b0, '0, 1'b0);
    chk("s3_idle_count", obs_q.size(), 0);
    frame(1'b0, 1'b0);
    same_as_ref("s3");

    // SOF injected at pixel (3,3)
    obs_q.delete();
    for (int n = 0; n < 27; n++) step(1'b1, n == 0, pix(n), 1'b0);
    step(1'b1, 1'b1, pix(0), 1'b0);
    chk("s4_err_rise", err_sof, 1);
    for (int n = 1; n < IW * IH; n++) step(1'b1, 1'b0, pix(n), 1'b0);
    repeat (3) step(1'b0, 1'b0, '0, 1'b0);
    chk("s4_count", obs_q.size(), 31);
    if (obs_q.size() > 7) begin
      chk("s4_prev_x", obs_q[6].x, 1);
      chk("s4_prev_y", obs_q[6].y, 2);
      chk("s4_next_x", obs_q[7].x, 1);
      chk("s4_next_y", obs_q[7].y, 1);
    end
    chk("s4_err_sticky", err_sof, 1);

    // Reset at pixel (5,3)
    obs_q.delete();
    for (int n = 0; n < 29; n++) step(1'b1, n == 0, pix(n), 1'b0);
    step(1'b1, 1'b0, pix(29), 1'b1);
    chk("s5_valid", out_valid, 0);
    chk("s5_win",   out_win,   0);
    chk("s5_x",     out_x,     0);
    chk("s5_y",     out_y,     0);
    chk("s5_eof",   out_eof,   0);
    chk("s5_err",   err_sof,   0);
    for (int n = 30; n < IW * IH; n++) step(1'b1, 1'b0, pix(n), 1'b0);
    repeat (2) step(1'b0, 1'b0, '0, 1'b0);
    chk("s5_count", obs_q.size(), 9);
    obs_q.delete();
    frame(1'b0, 1'b0);
    same_as_ref("s5");

    // All-negative data
    obs_q.delete();
    frame(1'b1, 1'b0);
    chk("s6_count", obs_q.size(), 24);
    if (obs_q.size() > 0) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          chk("s6_elem", el(obs_q[obs_q.size()-1].win, r, c), 32'h1FFFF);
    end

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
